// File: rtl/trig_capture_pkg.sv
// Shared constants for the event-trigger capture path: default sizes and
// the TriggerIn/TriggerOut bit positions the host-side wiring uses.
package trig_capture_pkg;

   localparam int DEF_N_EV  = 8;
   localparam int DEF_CNT_W = 8;

   // TriggerIn endpoint bit positions
   localparam int TRIGIN_SNAP_BIT = 0;
   localparam int TRIGIN_CLR_BIT  = 1;

   // TriggerOut endpoint bit position
   localparam int TRIGOUT_DONE_BIT = 0;

   // Width of a select bus able to address n entries, never narrower than 1
   function automatic int selWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/event_capture_cell.sv
// One event channel: optional rising-edge detect, sticky "seen" flag,
// saturating occurrence counter with overflow flag, and the clear logic.
// A clear keeps the event of its own cycle so nothing is lost at a window
// boundary.
module event_capture_cell #(
   parameter int CNT_W       = 8,
   parameter int EDGE_MODE   = 0,
   parameter int CLR_ON_SNAP = 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             ev_i,
   input  logic             clr_i,
   input  logic             snap_i,
   output logic             flag_o,
   output logic             ovf_o,
   output logic [CNT_W-1:0] count_o
);

   logic             evPrev_q;
   logic             flag_q, flag_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             evHit;
   logic             clear;

   // In edge mode only a 0->1 transition counts; prev is reset low so a
   // level already high at reset release counts once.
   assign evHit = (EDGE_MODE != 0) ? (ev_i & ~evPrev_q) : ev_i;
   assign clear = clr_i | (snap_i & (CLR_ON_SNAP != 0));

   // Next-state for flag, overflow and the saturating counter
   always_comb begin
      flag_d  = flag_q;
      ovf_d   = ovf_q;
      count_d = count_q;
      if (clear) begin
         flag_d  = evHit;
         ovf_d   = 1'b0;
         count_d = CNT_W'(evHit);
      end else if (evHit) begin
         flag_d = 1'b1;
         if (count_q == {CNT_W{1'b1}}) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   // Channel state registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         evPrev_q <= 1'b0;
         flag_q   <= 1'b0;
         ovf_q    <= 1'b0;
         count_q  <= '0;
      end else begin
         evPrev_q <= ev_i;
         flag_q   <= flag_d;
         ovf_q    <= ovf_d;
         count_q  <= count_d;
      end
   end

   assign flag_o  = flag_q;
   assign ovf_o   = ovf_q;
   assign count_o = count_q;

endmodule

// File: rtl/trigger_event_capture.sv
// Receiving end of the event-trigger path. Per-event capture cells keep
// live flags and counts; a host snapshot freezes them into a readable bank,
// answered by a one-cycle done pulse. A registered mux presents one count.
module trigger_event_capture
   import trig_capture_pkg::*;
#(
   parameter int N_EV        = DEF_N_EV,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int EDGE_MODE   = 0,
   parameter int CLR_ON_SNAP = 1
) (
   input  logic                      sys_clk,
   input  logic                      reset,
   input  logic [N_EV-1:0]           ev_in,
   input  logic                      snap_trig,
   input  logic                      clr_trig,
   input  logic [N_EV-1:0]           clr_mask,
   input  logic [selWidth(N_EV)-1:0] cnt_sel,
   output logic [N_EV-1:0]           live_flags,
   output logic [N_EV-1:0]           snap_flags,
   output logic [N_EV-1:0]           snap_ovf,
   output logic [CNT_W-1:0]          snap_cnt,
   output logic                      snap_done
);

   localparam int SEL_W = selWidth(N_EV);

   logic [N_EV-1:0]  liveOvf;
   logic [CNT_W-1:0] liveCnt [N_EV];

   logic [N_EV-1:0]  snapFlags_q;
   logic [N_EV-1:0]  snapOvf_q;
   logic [CNT_W-1:0] snapBank_q [N_EV];
   logic [CNT_W-1:0] snapCnt_q, snapCnt_d;
   logic             snapDone_q;

   for (genvar k = 0; k < N_EV; k++) begin : g_cell
      event_capture_cell #(
         .CNT_W       (CNT_W),
         .EDGE_MODE   (EDGE_MODE),
         .CLR_ON_SNAP (CLR_ON_SNAP)
      ) u_cell (
         .clk_i   (sys_clk),
         .reset_i (reset),
         .ev_i    (ev_in[k]),
         .clr_i   (clr_trig & clr_mask[k]),
         .snap_i  (snap_trig),
         .flag_o  (live_flags[k]),
         .ovf_o   (liveOvf[k]),
         .count_o (liveCnt[k])
      );
   end

   // Snapshot bank takes the pre-update live values on snap_trig
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         snapFlags_q <= '0;
         snapOvf_q   <= '0;
         for (int k = 0; k < N_EV; k++) begin
            snapBank_q[k] <= '0;
         end
      end else if (snap_trig) begin
         snapFlags_q <= live_flags;
         snapOvf_q   <= liveOvf;
         for (int k = 0; k < N_EV; k++) begin
            snapBank_q[k] <= liveCnt[k];
         end
      end
   end

   // Readout select; an out-of-range select reads as zero
   always_comb begin
      snapCnt_d = '0;
      for (int k = 0; k < N_EV; k++) begin
         if (cnt_sel == SEL_W'(k)) begin
            snapCnt_d = snapBank_q[k];
         end
      end
   end

   // Registered readout and the one-cycle done pulse
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         snapCnt_q  <= '0;
         snapDone_q <= 1'b0;
      end else begin
         snapCnt_q  <= snapCnt_d;
         snapDone_q <= snap_trig;
      end
   end

   assign snap_flags = snapFlags_q;
   assign snap_ovf   = snapOvf_q;
   assign snap_cnt   = snapCnt_q;
   assign snap_done  = snapDone_q;

endmodule

// File: tb/tb_trigger_event_capture.sv
// Directed bench: dutA is level mode with 8 events, dutB is edge mode with
// 6 events (so cnt_sel 6 and 7 are out of range). Both share the triggers.
module tb_trigger_event_capture;

   logic       sys_clk = 1'b0;
   logic       reset;
   logic [7:0] evA;
   logic [5:0] evB;
   logic       snapTrig, clrTrig;
   logic [7:0] clrMask;
   logic [2:0] cntSel;

   logic [7:0] liveFlagsA, snapFlagsA, snapOvfA, snapCntA;
   logic       snapDoneA;
   logic [5:0] liveFlagsB, snapFlagsB, snapOvfB;
   logic [7:0] snapCntB;
   logic       snapDoneB;

   int compareCount  = 0;
   int mismatchCount = 0;

   // Free-running clock
   always #5 sys_clk = ~sys_clk;

   trigger_event_capture #(
      .N_EV(8), .CNT_W(8), .EDGE_MODE(0), .CLR_ON_SNAP(1)
   ) dutA (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .ev_in      (evA),
      .snap_trig  (snapTrig),
      .clr_trig   (clrTrig),
      .clr_mask   (clrMask),
      .cnt_sel    (cntSel),
      .live_flags (liveFlagsA),
      .snap_flags (snapFlagsA),
      .snap_ovf   (snapOvfA),
      .snap_cnt   (snapCntA),
      .snap_done  (snapDoneA)
   );

   trigger_event_capture #(
      .N_EV(6), .CNT_W(8), .EDGE_MODE(1), .CLR_ON_SNAP(1)
   ) dutB (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .ev_in      (evB),
      .snap_trig  (snapTrig),
      .clr_trig   (clrTrig),
      .clr_mask   (clrMask[5:0]),
      .cnt_sel    (cntSel),
      .live_flags (liveFlagsB),
      .snap_flags (snapFlagsB),
      .snap_ovf   (snapOvfB),
      .snap_cnt   (snapCntB),
      .snap_done  (snapDoneB)
   );

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compareCount++;
      if (obs !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   // Drive one cycle of dutA events and triggers; one-cycle triggers drop after
   task automatic applyStimulus(input logic [7:0] ev, input logic snap, input logic clr,
                                input logic [7:0] mask);
      evA      = ev;
      snapTrig = snap;
      clrTrig  = clr;
      clrMask  = mask;
      tick();
      snapTrig = 1'b0;
      clrTrig  = 1'b0;
   endtask

   // Select a bank entry; snap_cnt shows it after one clock
   task automatic readCnt(input logic [2:0] sel);
      evA    = 8'h00;
      cntSel = sel;
      tick();
   endtask

   initial begin
      reset    = 1'b1;
      evA      = 8'h00;
      evB      = 6'h01;
      snapTrig = 1'b0;
      clrTrig  = 1'b0;
      clrMask  = 8'h00;
      cntSel   = 3'd0;
      tick();
      tick();
      checkOutput("rst_liveA", liveFlagsA, 0);
      checkOutput("rst_doneA", snapDoneA, 0);
      checkOutput("rst_cntA", snapCntA, 0);
      checkOutput("rst_snapFlagsA", snapFlagsA, 0);
      checkOutput("rst_liveB", liveFlagsB, 0);

      // Idle window then snapshot at cycle 5; dutB sees its held level once
      reset = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
      checkOutput("idle_liveB_level_once", liveFlagsB, 6'h01);
      checkOutput("idle_doneA_low", snapDoneA, 0);
      applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
      checkOutput("snap1_doneA", snapDoneA, 1);
      checkOutput("snap1_doneB", snapDoneB, 1);
      checkOutput("snap1_flagsA", snapFlagsA, 0);
      checkOutput("snap1_flagsB", snapFlagsB, 6'h01);
      checkOutput("snap1_liveB_cleared", liveFlagsB, 0);
      applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
      checkOutput("snap1_doneA_drop", snapDoneA, 0);
      for (int s = 0; s < 8; s++) begin
         readCnt(3'(s));
         checkOutput($sformatf("snap1_cntA_sel%0d", s), snapCntA, 0);
         checkOutput($sformatf("snap1_cntB_sel%0d", s), snapCntB, (s == 0) ? 1 : 0);
      end

      // Level mode counting: ev0 for 3 cycles, ev2 for 1
      applyStimulus(8'h05, 1'b0, 1'b0, 8'h00);
      applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
      applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
      checkOutput("lvl_liveA", liveFlagsA, 8'h05);
      applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
      checkOutput("lvl_snapFlagsA", snapFlagsA, 8'h05);
      checkOutput("lvl_liveA_cleared", liveFlagsA, 0);
      readCnt(3'd0); checkOutput("lvl_cnt0", snapCntA, 3);
      readCnt(3'd2); checkOutput("lvl_cnt2", snapCntA, 1);
      readCnt(3'd1); checkOutput("lvl_cnt1", snapCntA, 0);
      applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
      readCnt(3'd0); checkOutput("lvl_cnt0_after_clear", snapCntA, 0);
      checkOutput("lvl_snapFlagsA_empty", snapFlagsA, 0);

      // Saturation boundary: exactly 255 events, then 300 events
      for (int i = 0; i < 255; i++) applyStimulus(8'h02, 1'b0, 1'b0, 8'h00);
      applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
      checkOutput("sat255_ovf", snapOvfA, 0);
      readCnt(3'd1); checkOutput("sat255_cnt", snapCntA, 255);
      for (int i = 0; i < 300; i++) applyStimulus(8'h02, 1'b0, 1'b0, 8'h00);
      applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
      checkOutput("sat300_ovf", snapOvfA, 8'h02);
      readCnt(3'd1); checkOutput("sat300_cnt", snapCntA, 255);
      applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
      checkOutput("sat_reset_ovf", snapOvfA, 0);
      readCnt(3'd1); checkOutput("sat_reset_cnt", snapCntA, 0);

      // Event in the snapshot cycle lands in the next window
      applyStimulus(8'h08, 1'b1, 1'b0, 8'h00);
      checkOutput("snapev_flagsA", snapFlagsA, 0);
      checkOutput("snapev_liveA", liveFlagsA, 8'h08);
      readCnt(3'd3); checkOutput("snapev_cnt3_first", snapCntA, 0);
      applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
      checkOutput("snapev_flagsA_next", snapFlagsA, 8'h08);
      readCnt(3'd3); checkOutput("snapev_cnt3_next", snapCntA, 1);

      // Masked clear; an event in the clear cycle is kept
      applyStimulus(8'h03, 1'b0, 1'b0, 8'h00);
      applyStimulus(8'h03, 1'b0, 1'b0, 8'h00);
      applyStimulus(8'h00, 1'b0, 1'b1, 8'h01);
      checkOutput("clr_liveA", liveFlagsA, 8'h02);
      applyStimulus(8'h40, 1'b0, 1'b0, 8'h00);
      applyStimulus(8'h40, 1'b0, 1'b1, 8'h40);
      checkOutput("clr_ev_liveA", liveFlagsA, 8'h42);
      applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
      checkOutput("clr_snapFlagsA", snapFlagsA, 8'h42);
      readCnt(3'd0); checkOutput("clr_cnt0", snapCntA, 0);
      readCnt(3'd1); checkOutput("clr_cnt1", snapCntA, 2);
      readCnt(3'd6); checkOutput("clr_cnt6", snapCntA, 1);

      // Snapshot and clear together: snapshot sees pre-clear values
      applyStimulus(8'h20, 1'b0, 1'b0, 8'h00);
      applyStimulus(8'h20, 1'b0, 1'b0, 8'h00);
      applyStimulus(8'h00, 1'b1, 1'b1, 8'h20);
      checkOutput("snapclr_flagsA", snapFlagsA, 8'h20);
      checkOutput("snapclr_liveA", liveFlagsA, 0);
      readCnt(3'd5); checkOutput("snapclr_cnt5", snapCntA, 2);

      // Edge mode: ev4 high 10 cycles, low 1, high 2 -> two events
      evB = 6'h11;
      for (int i = 0; i < 10; i++) applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
      evB = 6'h01;
      applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
      evB = 6'h11;
      applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
      applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
      evB = 6'h01;
      applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
      checkOutput("edge_snapFlagsB", snapFlagsB, 6'h10);
      readCnt(3'd0); checkOutput("edge_cntB0_level", snapCntB, 0);
      readCnt(3'd6); checkOutput("edge_cntB_sel6_range", snapCntB, 0);
      readCnt(3'd7); checkOutput("edge_cntB_sel7_range", snapCntB, 0);
      readCnt(3'd4); checkOutput("edge_cntB4", snapCntB, 2);

      // Reset coinciding with a snapshot request wipes everything
      applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
      checkOutput("prerst_liveA", liveFlagsA, 8'h01);
      reset = 1'b1;
      applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
      checkOutput("rstsnap_doneA", snapDoneA, 0);
      checkOutput("rstsnap_doneB", snapDoneB, 0);
      checkOutput("rstsnap_flagsB", snapFlagsB, 0);
      checkOutput("rstsnap_cntB", snapCntB, 0);
      checkOutput("rstsnap_liveA", liveFlagsA, 0);
      reset = 1'b0;
      applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
      checkOutput("rstexit_doneA", snapDoneA, 0);
      checkOutput("rstexit_doneB", snapDoneB, 0);
      checkOutput("rstexit_liveB_level_once", liveFlagsB, 6'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
